color_stabilizer: RTL

- Downstream consumer of the colour-detection stage; runs on the same 1 MHz clock.
- Watches the filter-select and colour-code outputs and recognises each completed measurement round.
- Debounces the per-round colour into a stable colour, requiring N consecutive identical results.
- Keeps saturating per-colour tallies and flags a stalled sensor when rounds stop arriving.

---
 rtl/color_stabilizer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/color_stabilizer.sv
// color_stabilizer
//   Follows the colour-detection stage: spots each completed measurement round
//   (filter stepping 1 -> 2), debounces the round colour into a stable colour,
//   keeps saturating per-colour tallies and flags a sensor that stops producing
//   rounds.
// Ports:
//   clk_1MHz      system clock, rising edge
//   rst           asynchronous active-high reset
//   filter[1:0]   filter select from detect stage (2=clear, 3=green, 0=red, 1=blue)
//   color[1:0]    colour code from detect stage (0=none, 1=red, 2=green, 3=blue)
//   stable_color  debounced colour, same encoding as color
//   new_color     one-cycle pulse when stable_color changes
//   result_strobe one-cycle pulse per completed round
//   red/green/blue_tally  saturating round counts per colour
//   stall         high while no round has completed for TIMEOUT clocks
module color_stabilizer #(
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned TALLY_W    = 8,
  parameter int unsigned TIMEOUT    = 4000
) (
  input  logic               clk_1MHz,
  input  logic               rst,
  input  logic [1:0]         filter,
  input  logic [1:0]         color,
  output logic [1:0]         stable_color,
  output logic               new_color,
  output logic               result_strobe,
  output logic [TALLY_W-1:0] red_tally,
  output logic [TALLY_W-1:0] green_tally,
  output logic [TALLY_W-1:0] blue_tally,
  output logic               stall
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUAL,
    ST_LOCK
  } state_t;

  localparam logic [3:0]         STABLE_N  = 4'(STABLE_CNT);
  localparam bit                 SINGLE    = (STABLE_CNT == 1);
  localparam logic [15:0]        TIMEOUT_V = 16'(TIMEOUT);
  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  state_t             state_q, state_d;
  logic [1:0]         filter_prev_q, filter_prev_d;
  logic [1:0]         cand_q, cand_d;
  logic [3:0]         match_q, match_d;
  logic [1:0]         stable_q, stable_d;
  logic               new_color_q, new_color_d;
  logic               strobe_q, strobe_d;
  logic [TALLY_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]        timer_q, timer_d;
  logic               stall_q, stall_d;

  logic round_done;
  logic do_lock;

  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v,
                                                 input logic hit);
    if (hit && v != TALLY_MAX) return v + TALLY_W'(1);
    return v;
  endfunction

  always_comb begin
    round_done    = (filter == 2'd2) && (filter_prev_q == 2'd1);
    filter_prev_d = filter;
    strobe_d      = round_done;

    state_d     = state_q;
    cand_d      = cand_q;
    match_d     = match_q;
    stable_d    = stable_q;
    new_color_d = 1'b0;
    do_lock     = 1'b0;

    if (round_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (color != 2'd0) begin
            cand_d  = color;
            match_d = 4'd1;
            if (SINGLE) do_lock = 1'b1;
            else        state_d = ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (color == 2'd0) begin
            state_d = ST_IDLE;
            match_d = 4'd0;
          end else if (color == cand_q) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == STABLE_N) do_lock = 1'b1;
          end else begin
            cand_d  = color;
            match_d = 4'd1;
            if (SINGLE) do_lock = 1'b1;
          end
        end
        ST_LOCK: begin
          if (color == 2'd0) begin
            state_d = ST_IDLE;
          end else if (color != stable_q) begin
            state_d = ST_QUAL;
            cand_d  = color;
            match_d = 4'd1;
            if (SINGLE) do_lock = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Lock uses the candidate chosen in this same round, so a fresh
      // candidate can lock immediately when one result is enough.
      if (do_lock) begin
        state_d = ST_LOCK;
        match_d = 4'd0;
        if (cand_d != stable_q) begin
          stable_d    = cand_d;
          new_color_d = 1'b1;
        end
      end
    end

    red_d   = sat_inc(red_q,   round_done && color == 2'd1);
    green_d = sat_inc(green_q, round_done && color == 2'd2);
    blue_d  = sat_inc(blue_q,  round_done && color == 2'd3);

    // A completed round wins over a timeout seen in the same cycle.
    if (round_done)              timer_d = '0;
    else if (timer_q == 16'hFFFF) timer_d = timer_q;
    else                          timer_d = timer_q + 16'd1;
    stall_d = round_done ? 1'b0 : (timer_q >= TIMEOUT_V);
  end

  // filter_prev resets to the clear phase so releasing reset mid-round
  // cannot fake a 1 -> 2 transition.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      filter_prev_q <= 2'd2;
      cand_q        <= '0;
      match_q       <= '0;
      stable_q      <= '0;
      new_color_q   <= 1'b0;
      strobe_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      timer_q       <= '0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      filter_prev_q <= filter_prev_d;
      cand_q        <= cand_d;
      match_q       <= match_d;
      stable_q      <= stable_d;
      new_color_q   <= new_color_d;
      strobe_q      <= strobe_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      timer_q       <= timer_d;
      stall_q       <= stall_d;
    end
  end

  assign stable_color  = stable_q;
  assign new_color     = new_color_q;
  assign result_strobe = strobe_q;
  assign red_tally     = red_q;
  assign green_tally   = green_q;
  assign blue_tally    = blue_q;
  assign stall         = stall_q;

endmodule
